jvm_byte_feeder: RTL and testbench

//  Bytecode-side responder for the JVM->ARM translator: serves the iram/iram_ready byte stream and consumes its fetch pulses.

---
 rtl/jvm_byte_feeder.sv | 156 +++++++++++++++
 tb/tb_jvm_byte_feeder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/jvm_byte_feeder.sv
// Bytecode byte feeder: prefetches 32-bit words from bytecode memory into a small FIFO
// and presents them one byte at a time on iram/iram_ready for the JVM->ARM translator.
module jvm_byte_feeder #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [ADDRESS_WIDTH-1:0] byte_len,
  output logic                     mem_rd,
  output logic [ADDRESS_WIDTH-3:0] mem_addr,
  input  logic [31:0]              mem_rdata,
  output logic [7:0]               iram,
  output logic                     iram_ready,
  input  logic                     fetch,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] byte_pc
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [AW-3:0] r_rd_addr;
  logic [AW-2:0] r_words_left;
  logic          r_in_flight;
  logic [31:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_bytes_left;
  logic [AW-1:0] r_byte_pc;
  logic [1:0]    r_offset;

  logic          w_run;
  logic          w_accept;
  logic [AW:0]   w_span;
  logic [CW-1:0] w_occupancy;
  logic          w_mem_rd;
  logic          w_push;
  logic          w_ready;
  logic          w_take;
  logic          w_last;
  logic          w_pop;
  logic [31:0]   w_head;
  logic [7:0]    w_head_byte;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = (r_state == ST_IDLE) && start;

  // Words touched by the stream, counting the partial first word: ceil((offset + len) / 4).
  assign w_span = {1'b0, byte_len} + (AW+1)'(start_addr[1:0]) + (AW+1)'(3);

  // Reads in flight are counted as occupied slots so a returning word always has room.
  assign w_occupancy = r_count + {{(CW-1){1'b0}}, r_in_flight};
  assign w_mem_rd    = w_run && (r_words_left != '0) && (w_occupancy < CW'(FIFO_DEPTH));

  // Data returning while not in RUN (e.g. after the last fetch) is dropped.
  assign w_push  = r_in_flight && w_run;
  assign w_ready = w_run && (r_count != '0) && (r_bytes_left != '0);
  assign w_take  = fetch && w_ready;
  assign w_last  = w_take && (r_bytes_left == AW'(1));
  assign w_pop   = w_take && ((r_offset == 2'd3) || (r_bytes_left == AW'(1)));

  assign w_head      = r_fifo[r_rd_ptr];
  assign w_head_byte = w_head[8*r_offset +: 8];

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: every clocked register uses non-blocking assignment so all flops
      // sample pre-edge values; blocking here would create order-dependent races.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_next_state = (byte_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Read issue, FIFO bookkeeping and byte cursor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_addr    <= '0;
      r_words_left <= '0;
      r_in_flight  <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_bytes_left <= '0;
      r_byte_pc    <= '0;
      r_offset     <= '0;
    end else if (w_accept) begin
      r_rd_addr    <= start_addr[AW-1:2];
      r_words_left <= (byte_len == '0) ? '0 : w_span[AW:2];
      r_in_flight  <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_bytes_left <= byte_len;
      r_byte_pc    <= start_addr;
      r_offset     <= start_addr[1:0];
    end else begin
      r_in_flight <= w_mem_rd;
      if (w_mem_rd) begin
        r_rd_addr    <= r_rd_addr + 1'b1;
        r_words_left <= r_words_left - 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_take) begin
        r_bytes_left <= r_bytes_left - 1'b1;
        r_byte_pc    <= r_byte_pc + 1'b1;
        r_offset     <= r_offset + 1'b1;
      end
    end
  end

  // NOTE: the word storage has no reset; validity is tracked solely by the
  // pointers and count, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= mem_rdata;
  end

  assign mem_rd     = w_mem_rd;
  assign mem_addr   = r_rd_addr;
  assign iram       = w_ready ? w_head_byte : 8'h00;
  assign iram_ready = w_ready;
  assign busy       = w_run;
  assign done       = (r_state == ST_DONE);
  assign byte_pc    = r_byte_pc;

endmodule

// File: tb/tb_jvm_byte_feeder.sv
// Directed self-checking bench for jvm_byte_feeder: aligned/unaligned streams, backpressure,
// zero length, asynchronous reset mid-stream, and early fetch with an ignored restart.
module tb_jvm_byte_feeder;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] byte_len = '0;
  logic          mem_rd;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic [7:0]    iram;
  logic          iram_ready;
  logic          fetch = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] byte_pc;

  jvm_byte_feeder #(.ADDRESS_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .byte_len   (byte_len),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .iram       (iram),
    .iram_ready (iram_ready),
    .fetch      (fetch),
    .busy       (busy),
    .done       (done),
    .byte_pc    (byte_pc)
  );

  always #5 clk = ~clk;

  // Bytecode memory: sync read, data valid the cycle after mem_rd.
  logic [31:0]   mem [0:15];
  int            rd_count = 0;
  logic [AW-3:0] rd_log [0:255];

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr[3:0]];
      rd_log[rd_count[7:0]] = mem_addr;
      rd_count = rd_count + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Byte stored at byte address a: 11,22,..,88 for the first 8, then a*7+3.
  function automatic logic [7:0] exp_byte(input int a);
    if (a < 8) return 8'((a + 1) * 17);
    return 8'(a * 7 + 3);
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input int addr, input int len);
    start_addr = AW'(addr);
    byte_len   = AW'(len);
    start      = 1'b1;
    cyc();
    start      = 1'b0;
  endtask

  // Consume n bytes of a stream of len bytes starting at addr; check done if it was the last.
  task automatic run_stream(input int addr, input int len, input int n, input bit early,
                            input string tag);
    int cnt;
    for (int i = 0; i < n; i++) begin
      cnt   = 0;
      fetch = early;
      while (!iram_ready && cnt < 20) begin
        cyc();
        cnt++;
      end
      if (!iram_ready) begin
        check({tag, " ready_timeout"}, 32'd0, 32'd1);
        fetch = 1'b0;
        return;
      end
      check({tag, " iram"}, 32'(iram), 32'(exp_byte(addr + i)));
      check({tag, " byte_pc"}, 32'(byte_pc), 32'(addr + i));
      fetch = 1'b1;
      cyc();
    end
    fetch = 1'b0;
    if (n == len) begin
      check({tag, " done_pulse"}, 32'(done), 32'd1);
      check({tag, " busy_off"}, 32'(busy), 32'd0);
      cyc();
      check({tag, " done_clear"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int base;
    for (int w = 0; w < 16; w++)
      mem[w] = {exp_byte(4*w+3), exp_byte(4*w+2), exp_byte(4*w+1), exp_byte(4*w)};

    // Reset state
    #3;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst mem_rd", 32'(mem_rd), 32'd0);
    check("rst iram_ready", 32'(iram_ready), 32'd0);
    check("rst iram", 32'(iram), 32'd0);
    check("rst byte_pc", 32'(byte_pc), 32'd0);
    #9 reset = 1'b1;
    @(negedge clk);

    // 1: aligned 8-byte stream
    do_start(0, 8);
    base = rd_count;
    check("t1 busy", 32'(busy), 32'd1);
    check("t1 first mem_rd", 32'(mem_rd), 32'd1);
    check("t1 first mem_addr", 32'(mem_addr), 32'd0);
    run_stream(0, 8, 8, 1'b0, "t1");
    check("t1 read_count", 32'(rd_count - base), 32'd2);
    check("t1 addr0", 32'(rd_log[base[7:0]]), 32'd0);
    check("t1 addr1", 32'(rd_log[8'(base + 1)]), 32'd1);

    // 2: unaligned start
    do_start(2, 3);
    base = rd_count;
    run_stream(2, 3, 3, 1'b0, "t2");
    check("t2 read_count", 32'(rd_count - base), 32'd2);
    check("t2 addr0", 32'(rd_log[base[7:0]]), 32'd0);
    check("t2 addr1", 32'(rd_log[8'(base + 1)]), 32'd1);

    // 3: backpressure on a 6-word stream
    do_start(0, 24);
    base = rd_count;
    repeat (10) cyc();
    check("t3 hold iram", 32'(iram), 32'h11);
    check("t3 hold ready", 32'(iram_ready), 32'd1);
    check("t3 hold reads", 32'(rd_count - base), 32'd4);
    check("t3 hold mem_rd", 32'(mem_rd), 32'd0);
    run_stream(0, 24, 24, 1'b0, "t3");
    check("t3 read_count", 32'(rd_count - base), 32'd6);
    check("t3 last addr", 32'(rd_log[8'(base + 5)]), 32'd5);

    // 4: zero length
    base = rd_count;
    do_start(0, 0);
    check("t4 done", 32'(done), 32'd1);
    check("t4 busy", 32'(busy), 32'd0);
    check("t4 ready", 32'(iram_ready), 32'd0);
    cyc();
    check("t4 done_clear", 32'(done), 32'd0);
    check("t4 no reads", 32'(rd_count - base), 32'd0);

    // 5: asynchronous reset after 3 fetches, then a fresh stream
    do_start(0, 8);
    run_stream(0, 8, 3, 1'b0, "t5a");
    #2 reset = 1'b0;
    #1;
    check("t5 rst busy", 32'(busy), 32'd0);
    check("t5 rst done", 32'(done), 32'd0);
    check("t5 rst mem_rd", 32'(mem_rd), 32'd0);
    check("t5 rst mem_addr", 32'(mem_addr), 32'd0);
    check("t5 rst iram", 32'(iram), 32'd0);
    check("t5 rst ready", 32'(iram_ready), 32'd0);
    check("t5 rst byte_pc", 32'(byte_pc), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    do_start(4, 4);
    base = rd_count;
    run_stream(4, 4, 4, 1'b0, "t5b");
    check("t5 read_count", 32'(rd_count - base), 32'd1);
    check("t5 addr", 32'(rd_log[base[7:0]]), 32'd1);

    // 6: fetch held from start; a second start during RUN is ignored
    base  = rd_count;
    fetch = 1'b1;
    do_start(0, 8);
    start_addr = AW'(16);
    byte_len   = AW'(4);
    start      = 1'b1;
    cyc();
    start      = 1'b0;
    check("t6 busy", 32'(busy), 32'd1);
    run_stream(0, 8, 8, 1'b1, "t6");
    check("t6 read_count", 32'(rd_count - base), 32'd2);
    check("t6 addr1", 32'(rd_log[8'(base + 1)]), 32'd1);
    cyc();
    check("t6 idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
